// File: rtl/decomp_pkg.sv
// Shared types and constants for the decompressor SRAM arbiter and its requesters.
// Requesters use the plane offsets to place the U and V planes in SRAM.
package decomp_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    localparam int U_OFFSET = 38400;
    localparam int V_OFFSET = 57600;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request at or after `pointer`, wrapping,
// ignoring channels in `exclude`. Produces a one-hot pick and a found flag.
module rr_pick #(
    parameter int N_CH  = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_CH-1:0]  req,
    input  logic [PTR_W-1:0] pointer,
    input  logic [N_CH-1:0]  exclude,
    output logic [N_CH-1:0]  pick,
    output logic             found
);

    logic [N_CH-1:0]  cand;
    logic [PTR_W-1:0] idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        cand  = req & ~exclude;
        for (int k = 0; k < N_CH; k++) begin
            idx = PTR_W'((int'(pointer) + k) % N_CH);
            if (!found && cand[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decomp_sram_arbiter.sv
// Round-robin SRAM port arbiter with burst lock/cap for the decompressor requesters.
// Read data returns to the issuing channel through a fixed-latency tagged pipe.
module decomp_sram_arbiter
    import decomp_pkg::*;
#(
    parameter int N_CH         = 3,
    parameter int MAX_BURST    = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                        Clock,
    input  logic                        Resetn,
    input  logic [N_CH-1:0]             req,
    input  logic [N_CH*SRAM_ADDR_W-1:0] req_addr,
    input  logic [N_CH*SRAM_DATA_W-1:0] req_wdata,
    input  logic [N_CH-1:0]             req_we_n,
    output logic [N_CH-1:0]             grant,
    output logic [N_CH-1:0]             rvalid,
    output logic [SRAM_DATA_W-1:0]      rdata,
    output logic [SRAM_ADDR_W-1:0]      SRAM_address,
    output logic [SRAM_DATA_W-1:0]      SRAM_write_data,
    output logic                        SRAM_we_n,
    input  logic [SRAM_DATA_W-1:0]      SRAM_read_data,
    output arb_state_t                  arb_state
);

    localparam int TAG_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    // Valid/ready style contract: a channel's access happens in every cycle where
    // grant[i] and req[i] are both high; there is no separate strobe or stall.

    arb_state_t        state_q, state_d;
    logic [N_CH-1:0]   grant_q, grant_d;
    logic [TAG_W-1:0]  owner_q, owner_d;
    logic [TAG_W-1:0]  rr_q, rr_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;

    logic [N_CH-1:0]   pick_oh;
    logic              pick_found;
    logic [TAG_W-1:0]  pick_idx;
    logic [TAG_W-1:0]  pick_next;
    logic [TAG_W-1:0]  owner_next;
    logic              owner_req;
    logic              access;
    logic              read_access;

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [TAG_W-1:0]        pipe_tag [READ_LATENCY];

    // In ARB_OWN the pointer already sits at owner+1, so one picker serves both
    // the idle search and the owner-excluded re-arbitration.
    rr_pick #(
        .N_CH  (N_CH),
        .PTR_W (TAG_W)
    ) u_rr_pick (
        .req     (req),
        .pointer (rr_q),
        .exclude ((state_q == ARB_OWN) ? grant_q : '0),
        .pick    (pick_oh),
        .found   (pick_found)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (pick_oh[i]) pick_idx = TAG_W'(i);
        end
    end

    assign pick_next  = (pick_idx == TAG_W'(N_CH - 1)) ? '0 : pick_idx + TAG_W'(1);
    assign owner_next = (owner_q  == TAG_W'(N_CH - 1)) ? '0 : owner_q + TAG_W'(1);
    assign owner_req  = |(grant_q & req);
    assign access     = (state_q == ARB_OWN) && owner_req;

    always_comb begin
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_q[i] && req[i]) begin
                SRAM_address    = req_addr[i*SRAM_ADDR_W +: SRAM_ADDR_W];
                SRAM_write_data = req_wdata[i*SRAM_DATA_W +: SRAM_DATA_W];
                SRAM_we_n       = req_we_n[i];
            end
        end
    end

    assign read_access = access && SRAM_we_n;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d     = ARB_OWN;
                    grant_d     = pick_oh;
                    owner_d     = pick_idx;
                    rr_d        = pick_next;
                    burst_cnt_d = '0;
                end
            end
            ARB_OWN: begin
                if (!owner_req) begin
                    burst_cnt_d = '0;
                    if (pick_found) begin
                        grant_d = pick_oh;
                        owner_d = pick_idx;
                        rr_d    = pick_next;
                    end else begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                        rr_d    = owner_next;
                    end
                end else if (burst_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                    // Cap reached: hand over if anyone else waits, else restart the count.
                    burst_cnt_d = '0;
                    if (pick_found) begin
                        grant_d = pick_oh;
                        owner_d = pick_idx;
                        rr_d    = pick_next;
                    end
                end else begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_q        <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pipe_valid <= '0;
            for (int s = 0; s < READ_LATENCY; s++) pipe_tag[s] <= '0;
        end else begin
            pipe_valid[0] <= read_access;
            pipe_tag[0]   <= owner_q;
            for (int s = 1; s < READ_LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_tag[s]   <= pipe_tag[s-1];
            end
        end
    end

    always_comb begin
        rvalid = '0;
        for (int i = 0; i < N_CH; i++) begin
            rvalid[i] = pipe_valid[READ_LATENCY-1] && (pipe_tag[READ_LATENCY-1] == TAG_W'(i));
        end
    end

    assign rdata     = pipe_valid[READ_LATENCY-1] ? SRAM_read_data : '0;
    assign grant     = grant_q;
    assign arb_state = state_q;

endmodule

// File: tb/tb_decomp_sram_arbiter.sv
// Bench for decomp_sram_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural arbitration and read-return model.
module tb_decomp_sram_arbiter;
    import decomp_pkg::*;

    localparam int N_CH         = 3;
    localparam int MAX_BURST    = 8;
    localparam int READ_LATENCY = 2;
    localparam int EW           = 50;  // {ch[1:0], data[15:0], due_cycle[31:0]}

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic Resetn = 1'b0;
    always #5 clock = ~clock;

    logic [N_CH-1:0]             req;
    logic [N_CH*SRAM_ADDR_W-1:0] req_addr;
    logic [N_CH*SRAM_DATA_W-1:0] req_wdata;
    logic [N_CH-1:0]             req_we_n;
    logic [N_CH-1:0]             grant;
    logic [N_CH-1:0]             rvalid;
    logic [SRAM_DATA_W-1:0]      rdata;
    logic [SRAM_ADDR_W-1:0]      SRAM_address;
    logic [SRAM_DATA_W-1:0]      SRAM_write_data;
    logic                        SRAM_we_n;
    logic [SRAM_DATA_W-1:0]      SRAM_read_data;
    arb_state_t                  arb_state;

    decomp_sram_arbiter #(
        .N_CH         (N_CH),
        .MAX_BURST    (MAX_BURST),
        .READ_LATENCY (READ_LATENCY)
    ) dut (
        .Clock           (clock),
        .Resetn          (Resetn),
        .req             (req),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_we_n        (req_we_n),
        .grant           (grant),
        .rvalid          (rvalid),
        .rdata           (rdata),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .SRAM_read_data  (SRAM_read_data),
        .arb_state       (arb_state)
    );

    // SRAM model: data for the address presented two cycles earlier is addr + 0x100.
    logic [SRAM_ADDR_W-1:0] sram_a1 = '0;
    logic [SRAM_ADDR_W-1:0] sram_a2 = '0;
    always @(posedge clock) begin
        sram_a1 <= SRAM_address;
        sram_a2 <= sram_a1;
    end
    assign SRAM_read_data = sram_a2[15:0] + 16'h100;

    // ---------------- driver state ----------------
    logic [N_CH-1:0]        drv_req  = '0;
    logic [N_CH-1:0]        drv_we_n = '1;
    logic [SRAM_ADDR_W-1:0] drv_addr  [N_CH];
    logic [SRAM_DATA_W-1:0] drv_wdata [N_CH];

    // ---------------- reference model + scoreboard ----------------
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int cyc     = 0;
    logic [EW-1:0] exp_q[$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
        end
    endtask

    function automatic int pick(input logic [N_CH-1:0] r, input int start, input int excl);
        for (int k = 0; k < N_CH; k++) begin
            int c;
            c = (start + k) % N_CH;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        exp_q.delete();
    endtask

    task automatic apply_inputs();
        req      = drv_req;
        req_we_n = drv_we_n;
        for (int c = 0; c < N_CH; c++) begin
            req_addr[c*SRAM_ADDR_W +: SRAM_ADDR_W]  = drv_addr[c];
            req_wdata[c*SRAM_DATA_W +: SRAM_DATA_W] = drv_wdata[c];
        end
    endtask

    // One clock cycle, called just after a falling edge.
    task automatic cycle_body();
        logic [N_CH-1:0]        e_grant;
        logic [N_CH-1:0]        e_rvalid;
        logic [SRAM_DATA_W-1:0] e_rdata;
        logic [SRAM_ADDR_W-1:0] e_addr;
        logic [SRAM_DATA_W-1:0] e_wdata;
        logic                   e_we_n;
        logic [EW-1:0]          e;
        bit                     acc;
        int                     p;
        apply_inputs();
        #1;
        e_grant = '0;
        if (m_owner >= 0) e_grant[m_owner] = 1'b1;
        acc     = (m_owner >= 0) && drv_req[m_owner];
        e_addr  = acc ? drv_addr[m_owner]  : '0;
        e_wdata = acc ? drv_wdata[m_owner] : '0;
        e_we_n  = acc ? drv_we_n[m_owner]  : 1'b1;
        check("grant", 32'(grant), 32'(e_grant));
        check("state", 32'(arb_state), (m_owner >= 0) ? 32'(ARB_OWN) : 32'(ARB_IDLE));
        check("sram_addr", 32'(SRAM_address), 32'(e_addr));
        check("sram_wdata", 32'(SRAM_write_data), 32'(e_wdata));
        check("sram_we_n", 32'(SRAM_we_n), 32'(e_we_n));

        e_rvalid = '0;
        e_rdata  = '0;
        if (exp_q.size() > 0 && int'(exp_q[0][31:0]) == cyc) begin
            e = exp_q.pop_front();
            e_rvalid[e[49:48]] = 1'b1;
            e_rdata = e[47:32];
        end
        check("rvalid", 32'(rvalid), 32'(e_rvalid));
        if (e_rvalid != '0) check("rdata", 32'(rdata), 32'(e_rdata));

        if (acc && drv_we_n[m_owner])
            exp_q.push_back({2'(m_owner), drv_addr[m_owner][15:0] + 16'h100, 32'(cyc + READ_LATENCY)});

        if (m_owner < 0) begin
            p = pick(drv_req, m_ptr, -1);
            if (p >= 0) begin
                m_owner = p;
                m_ptr   = (p + 1) % N_CH;
                m_cnt   = 0;
            end
        end else if (!drv_req[m_owner]) begin
            p = pick(drv_req, (m_owner + 1) % N_CH, m_owner);
            m_ptr   = (p >= 0) ? (p + 1) % N_CH : (m_owner + 1) % N_CH;
            m_owner = p;
            m_cnt   = 0;
        end else if (m_cnt == MAX_BURST - 1) begin
            p = pick(drv_req, (m_owner + 1) % N_CH, m_owner);
            if (p >= 0) begin
                m_owner = p;
                m_ptr   = (p + 1) % N_CH;
            end
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clock);
        cycle_body();
    endtask

    task automatic set_ch(input int c, input bit r, input bit we_n,
                          input logic [SRAM_ADDR_W-1:0] a, input logic [SRAM_DATA_W-1:0] d);
        drv_req[c]   = r;
        drv_we_n[c]  = we_n;
        drv_addr[c]  = a;
        drv_wdata[c] = d;
    endtask

    task automatic randomize_payload();
        for (int c = 0; c < N_CH; c++) begin
            drv_addr[c]  = SRAM_ADDR_W'($urandom_range(0, 262143));
            drv_wdata[c] = SRAM_DATA_W'($urandom_range(0, 65535));
            drv_we_n[c]  = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int writes;
        for (int c = 0; c < N_CH; c++) set_ch(c, 1'b0, 1'b1, '0, '0);
        apply_inputs();
        repeat (3) @(posedge clock);

        // Reset values
        @(negedge clock);
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_we_n", 32'(SRAM_we_n), 32'h1);
        check("rst_addr", 32'(SRAM_address), 32'h0);
        check("rst_wdata", 32'(SRAM_write_data), 32'h0);
        check("rst_state", 32'(arb_state), 32'(ARB_IDLE));
        @(negedge clock);
        Resetn = 1'b1;
        model_reset();
        cycle_body();

        // ch1 alone: four reads at 0..3
        set_ch(1, 1'b1, 1'b1, 18'd0, 16'h0);
        step();
        for (int a = 0; a < 4; a++) begin
            drv_addr[1] = SRAM_ADDR_W'(a);
            step();
        end
        drv_req[1] = 1'b0;
        repeat (4) step();

        // ch0 and ch1 together from idle: alternate in blocks of MAX_BURST
        drv_req = 3'b011;
        for (int i = 0; i < 40; i++) begin
            randomize_payload();
            step();
        end
        drv_req = '0;
        repeat (4) step();

        // ch2 single write into the U plane
        set_ch(2, 1'b1, 1'b0, SRAM_ADDR_W'(U_OFFSET), 16'hABCD);
        step();
        step();
        drv_req[2] = 1'b0;
        repeat (3) step();

        // ch0 streams 20 writes alone, straight through the burst cap
        writes = 0;
        drv_req = 3'b001;
        step();
        for (int i = 0; i < 20; i++) begin
            set_ch(0, 1'b1, 1'b0, SRAM_ADDR_W'(V_OFFSET + i), SRAM_DATA_W'($urandom_range(0, 65535)));
            step();
            if (SRAM_we_n == 1'b0 && grant == 3'b001) writes++;
        end
        drv_req = '0;
        step();
        check("ch0_stream_writes", 32'(writes), 32'd20);
        repeat (3) step();

        // All three requesting continuously
        drv_req = 3'b111;
        for (int i = 0; i < 60; i++) begin
            randomize_payload();
            step();
        end
        drv_req = '0;
        repeat (4) step();

        // Reset between a read access and its return
        set_ch(1, 1'b1, 1'b1, 18'h155, 16'h0);
        step();
        step();
        @(negedge clock);
        Resetn = 1'b0;
        #1;
        check("midrst_grant", 32'(grant), 32'h0);
        check("midrst_we_n", 32'(SRAM_we_n), 32'h1);
        check("midrst_rvalid", 32'(rvalid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            check("inrst_rvalid", 32'(rvalid), 32'h0);
            check("inrst_grant", 32'(grant), 32'h0);
        end
        @(negedge clock);
        Resetn = 1'b1;
        model_reset();
        drv_req = 3'b011;
        drv_we_n = 3'b000;
        cycle_body();
        step();
        check("post_rst_grant", 32'(grant), 32'h1);
        for (int i = 0; i < 10; i++) step();
        drv_req = '0;
        repeat (4) step();

        // Random traffic with sticky request levels
        for (int i = 0; i < 500; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 7) == 0) drv_req[c] = ~drv_req[c];
            end
            randomize_payload();
            step();
        end
        drv_req = '0;
        repeat (5) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
